ifetch_buf: RTL and testbench

Parametrised instruction fetch unit with an on-chip instruction memory and a prefetch FIFO. It replaces the single-register fetch stage of the MIPS32 core. It sits between instruction memory and decode and decouples them with a valid/ready handshake. It also supports branch redirect with flush, halt-stop on the HLT opcode, and a program-load write port for "code" mode.

---
 rtl/ifetch_pkg.sv | 18 +
 rtl/ifb_fifo.sv | 60 ++++++
 rtl/ifetch_buf.sv | 129 ++++++++++++
 tb/tb_ifetch_buf.sv | 309 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ifetch_pkg.sv
// Shared constants and types for the prefetching instruction fetch unit.
package ifetch_pkg;

    localparam int          XLEN_DEF = 32;
    localparam logic [5:0]  OP_HLT   = 6'h3F;
    localparam int          OP_HI    = 31;
    localparam int          OP_LO    = 26;

    typedef struct packed {
        logic [XLEN_DEF-1:0] npc;
        logic [XLEN_DEF-1:0] ir;
    } fetch_entry_t;

    function automatic logic is_hlt(input logic [XLEN_DEF-1:0] word);
        return word[OP_HI:OP_LO] == OP_HLT;
    endfunction

endpackage

// File: rtl/ifb_fifo.sv
// Generic synchronous FIFO with flush; head is read combinationally.
// DEPTH must be a power of two so the pointers wrap naturally.
module ifb_fifo #(
    parameter int W     = 64,
    parameter int DEPTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   flush,
    input  logic                   push,
    input  logic [W-1:0]           push_data,
    input  logic                   pop,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   full,
    output logic                   empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          do_push;
    logic          do_pop;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    // Storage has no reset so it can map onto plain RAM cells.
    always_ff @(posedge clk) begin
        if (do_push && !rst && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + (AW+1)'(1);
            end else if (!do_push && do_pop) begin
                count <= count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: rtl/ifetch_buf.sv
// Instruction fetch unit: on-chip imem, one-cycle synchronous read, prefetch FIFO to decode.
// Define IFETCH_BUF_STATS_EN to add the stat_fetched / stat_stall counters.
module ifetch_buf
    import ifetch_pkg::*;
#(
    parameter int XLEN       = XLEN_DEF,
    parameter int IMEM_DEPTH = 1024,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          fetch_en,
    input  logic                          prog_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] prog_addr,
    input  logic [XLEN-1:0]               prog_data,
    input  logic                          redirect,
    input  logic [XLEN-1:0]               redirect_pc,
    output logic [XLEN-1:0]               ir,
    output logic [XLEN-1:0]               npc,
    output logic                          valid,
    input  logic                          ready,
    output logic                          halted
`ifdef IFETCH_BUF_STATS_EN
    ,
    output logic [31:0]                   stat_fetched,
    output logic [31:0]                   stat_stall
`endif
);

    localparam int AW = $clog2(IMEM_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [XLEN-1:0]   imem [IMEM_DEPTH];
    logic [XLEN-1:0]   pc;
    logic [AW-1:0]     pc_idx;
    logic [XLEN-1:0]   rdata_q;
    logic [XLEN-1:0]   tag_q;
    logic              inflight;
    logic              hlt_landing;
    logic              occ_blocked;
    logic              issue;
    logic              push;
    logic              pop;
    logic [2*XLEN-1:0] head;
    logic [CW-1:0]     count;
    logic              fifo_full;
    logic              fifo_empty;

    assign pc_idx = AW'(pc % XLEN'(IMEM_DEPTH));

    // Every issue reserves a FIFO slot, so count+inflight is the true occupancy.
    assign occ_blocked = fifo_full || (inflight && count == CW'(FIFO_DEPTH - 1));
    assign hlt_landing = inflight && is_hlt(rdata_q[31:0]);
    assign issue       = fetch_en && !halted && !redirect && !hlt_landing && !occ_blocked;
    assign push        = inflight && !redirect;

    // valid/ready: the head entry transfers to decode on every rising edge where
    // valid && ready are both high; valid only drops without a transfer on redirect or rst.
    assign pop   = valid && ready && !redirect;
    assign valid = !fifo_empty;
    assign ir    = valid ? head[XLEN-1:0]      : '0;
    assign npc   = valid ? head[2*XLEN-1:XLEN] : '0;

    always_ff @(posedge clk) begin
        if (prog_we) begin
            imem[prog_addr] <= prog_data;
        end
    end

    always_ff @(posedge clk) begin
        if (issue && !rst) begin
            rdata_q <= imem[pc_idx];
            tag_q   <= pc + XLEN'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc       <= '0;
            inflight <= 1'b0;
            halted   <= 1'b0;
        end else if (redirect) begin
            pc       <= redirect_pc;
            inflight <= 1'b0;
            halted   <= 1'b0;
        end else begin
            if (issue) begin
                pc <= pc + XLEN'(1);
            end
            inflight <= issue;
            if (push && hlt_landing) begin
                halted <= 1'b1;
            end
        end
    end

    ifb_fifo #(
        .W     (2 * XLEN),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect),
        .push      (push),
        .push_data ({tag_q, rdata_q}),
        .pop       (pop),
        .head      (head),
        .count     (count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

`ifdef IFETCH_BUF_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_fetched <= '0;
            stat_stall   <= '0;
        end else begin
            if (push && stat_fetched != '1) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (fetch_en && !halted && occ_blocked && stat_stall != '1) begin
                stat_stall <= stat_stall + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_ifetch_buf.sv
// Directed self-checking bench for ifetch_buf: fill, backpressure, redirect, halt, reset, stats.
module tb_ifetch_buf;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        prog_we;
    logic [9:0]  prog_addr;
    logic [31:0] prog_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic [31:0] ir;
    logic [31:0] npc;
    logic        valid;
    logic        ready;
    logic        halted;
`ifdef IFETCH_BUF_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_stall;
`endif

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_q[$];

    localparam logic [31:0] HLT_WORD = 32'hFC00_0000;

    always #5 clk = ~clk;

    ifetch_buf dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .prog_we     (prog_we),
        .prog_addr   (prog_addr),
        .prog_data   (prog_data),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .ir          (ir),
        .npc         (npc),
        .valid       (valid),
        .ready       (ready),
        .halted      (halted)
`ifdef IFETCH_BUF_STATS_EN
        ,
        .stat_fetched (stat_fetched),
        .stat_stall   (stat_stall)
`endif
    );

    // ADD r(i), r1, r2 -- distinct per address, opcode 0.
    function automatic logic [31:0] gen_word(input int i);
        logic [4:0] rd;
        rd = i[4:0];
        return {6'h00, 5'd1, 5'd2, rd, 5'd0, 6'h20};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_word(input int a, input logic [31:0] d);
        prog_we   = 1'b1;
        prog_addr = 10'(a);
        prog_data = d;
        tick();
        prog_we   = 1'b0;
    endtask

    // Two reset edges, then release with fetch enabled; next edge is E1.
    task automatic start(input logic rdy);
        rst      = 1'b1;
        fetch_en = 1'b0;
        ready    = 1'b0;
        redirect = 1'b0;
        tick();
        tick();
        rst      = 1'b0;
        fetch_en = 1'b1;
        ready    = rdy;
    endtask

    task automatic test_reset();
        rst = 1'b1; fetch_en = 1'b1; ready = 1'b1; redirect = 1'b0;
        redirect_pc = '0; prog_we = 1'b0; prog_addr = '0; prog_data = '0;
        for (int i = 0; i < 32; i++) write_word(i, gen_word(i));
        checks++;
        if (valid !== 1'b0 || halted !== 1'b0 || ir !== 32'h0 || npc !== 32'h0) begin
            $display("FAIL reset: valid=%b halted=%b ir=%h npc=%h, expected all zero",
                     valid, halted, ir, npc);
            errors++;
        end
    endtask

    task automatic test_fill();
        start(1'b1);
        tick();
        checks++;
        if (valid !== 1'b0) begin
            $display("FAIL fill_e1: valid=%b expected 0", valid);
            errors++;
        end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || ir !== gen_word(k) || npc !== 32'(k + 1)) begin
                $display("FAIL fill_w%0d: valid=%b ir=%h npc=%0d expected valid=1 ir=%h npc=%0d",
                         k, valid, ir, npc, gen_word(k), k + 1);
                errors++;
            end
        end
    endtask

    task automatic test_backpressure();
        start(1'b0);
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (k >= 2) begin
                checks++;
                if (valid !== 1'b1 || ir !== gen_word(0)) begin
                    $display("FAIL bp_hold_c%0d: valid=%b ir=%h expected valid=1 ir=%h",
                             k, valid, ir, gen_word(0));
                    errors++;
                end
            end
        end
        ready = 1'b1;
        for (int k = 0; k < 6; k++) exp_q.push_back(gen_word(k));
        for (int k = 0; k < 6; k++) begin
            logic [31:0] e;
            e = exp_q.pop_front();
            checks++;
            if (valid !== 1'b1 || ir !== e) begin
                $display("FAIL bp_drain_%0d: valid=%b ir=%h expected valid=1 ir=%h",
                         k, valid, ir, e);
                errors++;
            end
            tick();
        end
    endtask

    task automatic test_redirect();
        start(1'b0);
        for (int k = 0; k < 4; k++) tick();
        checks++;
        if (valid !== 1'b1 || ir !== gen_word(0)) begin
            $display("FAIL redir_pre: valid=%b ir=%h expected valid=1 ir=%h", valid, ir, gen_word(0));
            errors++;
        end
        redirect = 1'b1; redirect_pc = 32'd20; ready = 1'b1;
        tick();
        redirect = 1'b0; ready = 1'b0;
        checks++;
        if (valid !== 1'b0) begin
            $display("FAIL redir_flush: valid=%b expected 0", valid);
            errors++;
        end
        tick();
        checks++;
        if (valid !== 1'b0) begin
            $display("FAIL redir_e1: valid=%b expected 0", valid);
            errors++;
        end
        for (int k = 20; k < 23; k++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || ir !== gen_word(k) || npc !== 32'(k + 1)) begin
                $display("FAIL redir_w%0d: valid=%b ir=%h npc=%0d expected valid=1 ir=%h npc=%0d",
                         k, valid, ir, npc, gen_word(k), k + 1);
                errors++;
            end
            ready = 1'b1;
        end
    endtask

    task automatic test_fetch_en();
        start(1'b0);
        tick();
        fetch_en = 1'b0;
        tick();
        checks++;
        if (valid !== 1'b1 || ir !== gen_word(0)) begin
            $display("FAIL fen_land: valid=%b ir=%h expected valid=1 ir=%h", valid, ir, gen_word(0));
            errors++;
        end
        tick();
        tick();
        ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            tick();
            checks++;
            if (valid !== 1'b0) begin
                $display("FAIL fen_idle_%0d: valid=%b expected 0", k, valid);
                errors++;
            end
        end
    endtask

    task automatic test_halt();
        write_word(3, HLT_WORD);
        start(1'b1);
        tick();
        for (int k = 0; k < 4; k++) begin
            logic [31:0] e;
            e = (k == 3) ? HLT_WORD : gen_word(k);
            tick();
            checks++;
            if (valid !== 1'b1 || ir !== e || halted !== (k == 3)) begin
                $display("FAIL halt_w%0d: valid=%b ir=%h halted=%b expected valid=1 ir=%h halted=%b",
                         k, valid, ir, halted, e, k == 3);
                errors++;
            end
        end
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (valid !== 1'b0 || halted !== 1'b1) begin
                $display("FAIL halt_idle_%0d: valid=%b halted=%b expected valid=0 halted=1",
                         k, valid, halted);
                errors++;
            end
        end
        redirect = 1'b1; redirect_pc = 32'd8;
        tick();
        redirect = 1'b0;
        checks++;
        if (valid !== 1'b0 || halted !== 1'b0) begin
            $display("FAIL halt_redir: valid=%b halted=%b expected valid=0 halted=0", valid, halted);
            errors++;
        end
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || ir !== gen_word(8) || npc !== 32'd9) begin
            $display("FAIL halt_w8: valid=%b ir=%h npc=%0d expected valid=1 ir=%h npc=9",
                     valid, ir, npc, gen_word(8));
            errors++;
        end
        write_word(3, gen_word(3));
    endtask

    task automatic test_reset_mid();
        start(1'b0);
        for (int k = 0; k < 6; k++) tick();
        rst = 1'b1;
        tick();
        checks++;
        if (valid !== 1'b0 || halted !== 1'b0 || ir !== 32'h0 || npc !== 32'h0) begin
            $display("FAIL rstmid: valid=%b halted=%b ir=%h npc=%h expected all zero",
                     valid, halted, ir, npc);
            errors++;
        end
        rst = 1'b0; ready = 1'b1;
        tick();
        for (int k = 0; k < 4; k++) begin
            tick();
            checks++;
            if (valid !== 1'b1 || ir !== gen_word(k) || npc !== 32'(k + 1)) begin
                $display("FAIL rstmid_w%0d: valid=%b ir=%h npc=%0d expected valid=1 ir=%h npc=%0d",
                         k, valid, ir, npc, gen_word(k), k + 1);
                errors++;
            end
        end
    endtask

`ifdef IFETCH_BUF_STATS_EN
    task automatic test_stats();
        start(1'b0);
        checks++;
        if (stat_fetched !== 32'd0 || stat_stall !== 32'd0) begin
            $display("FAIL stats_reset: fetched=%0d stall=%0d expected 0 0", stat_fetched, stat_stall);
            errors++;
        end
        for (int k = 0; k < 8; k++) tick();
        ready = 1'b1;
        for (int k = 0; k < 3; k++) tick();
        fetch_en = 1'b0;
        for (int k = 0; k < 3; k++) tick();
        checks++;
        if (stat_fetched !== 32'd6 || stat_stall !== 32'd5) begin
            $display("FAIL stats: fetched=%0d stall=%0d expected 6 5", stat_fetched, stat_stall);
            errors++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_backpressure();
        test_redirect();
        test_fetch_en();
        test_halt();
        test_reset_mid();
`ifdef IFETCH_BUF_STATS_EN
        test_stats();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
